// File: rtl/md_unit_pkg.sv
// md_unit shared definitions: MDOp encodings, default latencies and the
// combinational multiply/divide result function.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

  // Returns {HI,LO}; a zero divisor is replaced so no X is produced.
  function automatic logic [63:0] md_calc(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] r;
    logic [31:0] bd;
    r  = '0;
    bd = (b == 32'd0) ? 32'd1 : b;
    case (op)
      MD_MULT:
        r = $signed({{32{a[31]}}, a}) *
            $signed({{32{b[31]}}, b});
      MD_MULTU:
        r = {32'd0, a} * {32'd0, b};
      MD_DIV:
        if (a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF)
          r = {32'd0, a};
        else
          r = {$signed(a) % $signed(bd),
               $signed(a) / $signed(bd)};
      MD_DIVU:
        r = {a % bd, a / bd};
      default:
        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit operand/result bundle between EX stage
// control (master) and the multiply/divide unit (slave).
interface md_unit_if;

  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDOp, A, B,
    input  busy, stall_req, HI, LO
  );

  modport slave (
    input  start, MDOp, A, B,
    output busy, stall_req, HI, LO
  );

endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: HI/LO registers with modelled
// mult/div latency via a busy down-counter.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave md
);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             dz;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic             busy;
  logic             is_long;
  logic             is_div;

  assign busy    = (cnt != '0);
  assign is_long = (md.MDOp <= 3'd3);
  assign is_div  = is_long & md.MDOp[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      pend <= '0;
      dz   <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      // Divide-by-zero completes silently, HI/LO untouched
      if (cnt == CNT_W'(1) && !dz)
        {hi, lo} <= pend;
    end else if (md.start) begin
      if (is_long) begin
        pend <= md_calc(md.MDOp, md.A, md.B);
        dz   <= is_div && (md.B == 32'd0);
        cnt  <= is_div ? CNT_W'(DIV_CYCLES)
                       : CNT_W'(MULT_CYCLES);
      end else if (md.MDOp == MD_MTHI) begin
        hi <= md.A;
      end else if (md.MDOp == MD_MTLO) begin
        lo <= md.A;
      end
    end
  end

  assign md.busy      = busy;
  assign md.stall_req = busy | (md.start & is_long);
  assign md.HI        = hi;
  assign md.LO        = lo;

endmodule
